// File: rtl/bcd_7seg_if.sv
// Capture/display bus for one bcd_7seg digit: code and enable in, segment drives and error flag out.
interface bcd_7seg_if;
    logic       en;
    logic [3:0] bcd_in;
    logic [6:0] seg_out;
    logic       invalid;

    modport master (
        output en,
        output bcd_in,
        input  seg_out,
        input  invalid
    );

    modport slave (
        input  en,
        input  bcd_in,
        output seg_out,
        output invalid
    );
endinterface

// File: rtl/bcd_7seg.sv
// Registered BCD to common-anode seven-segment decoder, active-low segments {g,f,e,d,c,b,a}.
// Define BCD_HEX_EN to show hex glyphs A-F for codes 10-15 instead of blanking the digit.
module bcd_7seg (
    input  logic         clk,
    input  logic         rst_n,
    bcd_7seg_if.slave    bus
);

    logic [6:0] r_seg_p1;
    logic       r_invalid_p1;
    logic [6:0] w_seg_p0;
    logic       w_invalid_p0;

    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
`ifdef BCD_HEX_EN
            4'd10:   seg = 7'h08;
            4'd11:   seg = 7'h03;
            4'd12:   seg = 7'h46;
            4'd13:   seg = 7'h21;
            4'd14:   seg = 7'h06;
            default: seg = 7'h0E;
`else
            default: seg = 7'h7F;
`endif
        endcase
        return seg;
    endfunction

    function automatic logic f_is_invalid(input logic [3:0] code);
        return (code > 4'd9);
    endfunction

    assign w_seg_p0     = f_decode(bus.bcd_in);
    assign w_invalid_p0 = f_is_invalid(bus.bcd_in);

    // p0 -> p1: capture decoded code; both outputs share one register stage so they never skew
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_p1     <= 7'h7F;
            r_invalid_p1 <= 1'b0;
        end else if (bus.en) begin
            r_seg_p1     <= w_seg_p0;
            r_invalid_p1 <= w_invalid_p0;
        end
    end

    assign bus.seg_out = r_seg_p1;
    assign bus.invalid = r_invalid_p1;

endmodule

// File: tb/tb_bcd_7seg.sv
// Table-driven scoreboard bench for bcd_7seg: sweep, hold, reset and flag-alignment sequences.
module tb_bcd_7seg;

    typedef struct {
        logic [3:0] bcd;
        logic [6:0] seg;
        logic       inv;
    } vec_t;

    typedef struct {
        logic [6:0] seg;
        logic       inv;
    } exp_t;

    logic clk;
    logic rst_n;
    bcd_7seg_if u_if ();

    bcd_7seg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl [16];
    exp_t sb [$];
    exp_t held;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input exp_t e);
        checks++;
        if (u_if.seg_out !== e.seg || u_if.invalid !== e.inv) begin
            errors++;
            $display("FAIL %s: got seg=%h inv=%b, want seg=%h inv=%b",
                     nm, u_if.seg_out, u_if.invalid, e.seg, e.inv);
        end
    endtask

    // One cycle: drive at negedge, push expectation, compare #1 after the capturing edge.
    task automatic drive(input logic [3:0] code, input logic e, input string nm);
        exp_t got;
        @(negedge clk);
        u_if.bcd_in = code;
        u_if.en     = e;
        if (e && rst_n) begin
            held.seg = tbl[code].seg;
            held.inv = tbl[code].inv;
        end
        sb.push_back(held);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            got = sb.pop_front();
            check(nm, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] dec [16];
        dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
`ifdef BCD_HEX_EN
                7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
        for (int i = 0; i < 16; i++) begin
            tbl[i].bcd = 4'(i);
            tbl[i].seg = dec[i];
            tbl[i].inv = (i > 9);
        end

        // Reset: asynchronous blanking with no clock edge
        u_if.en     = 1'b1;
        u_if.bcd_in = 4'd8;
        rst_n       = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        held = '{7'h7F, 1'b0};
        check("reset_async", held);
        @(posedge clk);
        #1;
        check("reset_over_en", held);
        drive(4'd8, 1'b1, "reset_held");
        rst_n = 1'b1;
        drive(4'd8, 1'b1, "reset_release_8");

        // Exhaustive sweep from the table
        for (int i = 0; i < 16; i++)
            drive(tbl[i].bcd, 1'b1, $sformatf("sweep_%0d", i));

        // Hold with en low
        drive(4'd5, 1'b1, "hold_capture_5");
        for (int i = 0; i < 3; i++)
            drive(4'd2, 1'b0, $sformatf("hold_cycle_%0d", i));
        drive(4'd2, 1'b1, "hold_release_2");

        // Mid-stream reset at code 6
        for (int i = 0; i < 6; i++)
            drive(4'(i), 1'b1, $sformatf("mid_sweep_%0d", i));
        @(negedge clk);
        u_if.bcd_in = 4'd6;
        rst_n = 1'b0;
        #1;
        held = '{7'h7F, 1'b0};
        check("mid_reset_async", held);
        @(posedge clk);
        #1;
        check("mid_reset_hold", held);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd6, 1'b1, "mid_release_6");
        drive(4'd7, 1'b1, "mid_next_7");

        // Invalid-flag alignment: alternate 9 and 10
        for (int i = 0; i < 8; i++)
            drive((i % 2) ? 4'd10 : 4'd9, 1'b1, $sformatf("align_%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_7seg.md
# bcd_7seg

Registered BCD-to-seven-segment decoder for a single common-anode digit. Each clock it converts a 4-bit BCD code into active-low segment drives and flags codes outside 0–9. It sits between the counter/datapath logic and the display pins, one instance per digit.

## Interface

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  capture enable; when low, outputs hold their current value
- bcd_in  input  4  BCD code to display, valid 0–9
- seg_out  output  7  segment drives, active-low (0 = segment lit), bit order {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a)
- invalid  output  1  high when the captured code is 10–15

## Operation

- Decimal map, seg_out in hex:
  - 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19
  - 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10
- Codes 10–15: seg_out = 0x7F (all segments dark), invalid = 1. This applies unless BCD_HEX_EN is defined.
- Codes 0–9: invalid = 0.
- Decode is a pure function of the captured code. There is no other state.
- The bench feeds bcd_in from an integer loop 0–15, so all 16 codes must decode deterministically. No X or Z may reach any output.

## Timing

- Reset:
  - While rst_n = 0, seg_out = 0x7F and invalid = 0, asynchronously.
  - Reset takes priority over en.
  - Release is synchronised by the first rising clk edge after rst_n goes high.
- Latency is 1 cycle. With en = 1, the value of bcd_in sampled at rising edge N appears on seg_out and invalid after edge N, stable until edge N+1.
- With en = 0, seg_out and invalid keep their values indefinitely, with no decode of bcd_in.
- Both outputs update on the same edge. They are never skewed by a cycle.
- Reset asserted mid-operation blanks the display immediately. The next valid code appears one edge after reset releases with en = 1.
- bcd_in changing back-to-back every cycle yields a new decode every cycle. There are no bubbles.

## Configuration

- Macro BCD_HEX_EN.
- When undefined (default):
  - Codes 10–15 blank the digit (0x7F).
  - invalid = 1 for those codes.
- When defined, codes 10–15 show hex glyphs:
  - A→0x08, b→0x03, C→0x46, d→0x21, E→0x06, F→0x0E
  - invalid is still 1 for 10–15, so downstream error handling is unchanged.
- Codes 0–9 behave identically in both builds.

## Test plan

- Reset:
  - Drive rst_n = 0 with bcd_in = 8.
  - Check that seg_out = 0x7F and invalid = 0 without a clock edge.
  - Release reset and, with en = 1, check seg_out = 0x00 one edge later.
- Exhaustive sweep:
  - With en = 1, drive bcd_in 0→15, one code per cycle.
  - Check seg_out against the decimal map one cycle later.
  - Check 0x7F with invalid = 1 for 10–15; with BCD_HEX_EN defined, check the hex glyphs instead.
- Hold:
  - Capture 5, giving 0x12.
  - Drop en and change bcd_in to 2.
  - Check that seg_out stays 0x12 for 3 cycles.
  - Raise en and check 0x24 one edge later.
- Mid-stream reset:
  - While sweeping, assert rst_n at code 6.
  - Check that seg_out goes to 0x7F immediately.
  - After release, check that the next captured code decodes correctly after one edge.
- Invalid-flag alignment:
  - Alternate 9 and 10 every cycle.
  - Check that seg_out toggles 0x10 and 0x7F while invalid toggles 0 and 1 on the same edges.
